// File: rtl/alu_pkg.sv
// Shared types and helpers for the multi-cycle ALU: op codes, FSM states,
// and signed-overflow detection for add/subtract.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'b0000,
      OP_ADD   = 4'b0001,
      OP_SUB   = 4'b0010,
      OP_SLT   = 4'b0011,
      OP_SRL   = 4'b0100,
      OP_SRA   = 4'b0101,
      OP_SLL   = 4'b0110,
      OP_RSV7  = 4'b0111,
      OP_OR    = 4'b1000,
      OP_XOR   = 4'b1001,
      OP_NOR   = 4'b1010,
      OP_SLTU  = 4'b1011,
      OP_MULU  = 4'b1100,
      OP_MUL   = 4'b1101,
      OP_RSVE  = 4'b1110,
      OP_RSVF  = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // Two's-complement overflow from the sign bits alone: the operands (with the
   // subtrahend inverted for SUB) agree in sign but the result does not.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic is_sub);
      logic b_eff;
      b_eff = is_sub ? ~b_msb : b_msb;
      return (a_msb == b_eff) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative radix-2 shift-add multiplier on operand magnitudes.
// Iteration 0 runs on the start edge straight from the inputs; iterations
// 1..WIDTH-1 run from the registered partial product while cnt is non-zero.
// 'done' marks the cycle whose edge completes the last iteration, and
// 'product' then carries the finished, sign-corrected 2*WIDTH result so the
// caller can register it on that same edge.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int SHAMT_W = $clog2(WIDTH);

   logic [WIDTH-1:0]   hi, lo, mag_a_r;
   logic               neg_r;
   logic [SHAMT_W-1:0] cnt;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   step_hi, step_lo, step_m;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] step_p;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which
   // still fits as an unsigned WIDTH-bit number.
   always_comb begin
      mag_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
      mag_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
   end

   // One shift-add step: add the multiplicand when the low bit is set, then
   // shift the {carry, hi, lo} window right by one.
   always_comb begin
      step_hi = start ? '0    : hi;
      step_lo = start ? mag_b : lo;
      step_m  = start ? mag_a : mag_a_r;
      sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, step_m} : '0);
      step_p  = {sum, step_lo[WIDTH-1:1]};
      done    = (cnt == SHAMT_W'(WIDTH - 1));
      product = neg_r ? (~step_p + 1'b1) : step_p;
   end

   // Partial-product and iteration-counter registers; cnt wraps back to 0
   // after the final iteration, which also marks the unit idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi      <= '0;
         lo      <= '0;
         mag_a_r <= '0;
         neg_r   <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         hi      <= step_p[2*WIDTH-1:WIDTH];
         lo      <= step_p[WIDTH-1:0];
         mag_a_r <= mag_a;
         neg_r   <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
         cnt     <= SHAMT_W'(1);
      end else if (cnt != '0) begin
         hi      <= step_p[2*WIDTH-1:WIDTH];
         lo      <= step_p[WIDTH-1:0];
         cnt     <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Registered, back-pressurable execute unit: single-cycle logic/arith/shift
// ops plus an iterative multiplier returning a double-width product.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. out_valid
// and in_ready depend only on state (and out_ready), never on in_valid, and
// z/z_hi/flags stay constant while out_valid is high until the result transfers.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   z,
   output logic [WIDTH-1:0]   z_hi,
   output logic               zero,
   output logic               equal,
   output logic               overflow,
   output logic               illegal,
   output alu_state_e         dbg_state
);

   localparam int SHAMT_W = $clog2(WIDTH);

   alu_state_e         state, state_next;
   alu_op_e            op_e;
   logic               accept, is_mul_op;
   logic [SHAMT_W-1:0] sh;
   logic [WIDTH-1:0]   sum, diff, alu_z;
   logic               alu_ovf, alu_ill, alu_zero, alu_equal;
   logic               mul_start, mul_done, mul_signed_r, mul_ovf;
   logic [2*WIDTH-1:0] mul_product;

   assign op_e      = alu_op_e'(op);
   assign is_mul_op = (op_e == OP_MUL) || (op_e == OP_MULU);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && is_mul_op;
   assign dbg_state = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; DONE with out_ready behaves like IDLE for a new request.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = is_mul_op ? MUL : DONE;
         MUL:  if (mul_done) state_next = DONE;
         DONE: begin
            if (out_ready) begin
               if (in_valid) state_next = is_mul_op ? MUL : DONE;
               else          state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs derived from state.
   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
   end

   // Single-cycle result and flags from the presented operands.
   always_comb begin
      sh      = y[SHAMT_W-1:0];
      sum     = x + y;
      diff    = x - y;
      alu_z   = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (op_e)
         OP_AND:  alu_z = x & y;
         OP_ADD:  begin
            alu_z   = sum;
            alu_ovf = signed_ovf(x[WIDTH-1], y[WIDTH-1], sum[WIDTH-1], 1'b0);
         end
         OP_SUB:  begin
            alu_z   = diff;
            alu_ovf = signed_ovf(x[WIDTH-1], y[WIDTH-1], diff[WIDTH-1], 1'b1);
         end
         OP_SLT:  alu_z = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         OP_SRL:  alu_z = x >> sh;
         OP_SRA:  alu_z = $signed(x) >>> sh;
         OP_SLL:  alu_z = x << sh;
         OP_OR:   alu_z = x | y;
         OP_XOR:  alu_z = x ^ y;
         OP_NOR:  alu_z = ~(x | y);
         OP_SLTU: alu_z = {{(WIDTH-1){1'b0}}, (x < y)};
         OP_MUL, OP_MULU: alu_z = '0;
         default: alu_ill = 1'b1;
      endcase
      alu_zero  = !alu_ill && (alu_z == '0);
      alu_equal = !alu_ill && (x == y);
   end

   // Multiply overflow: high half is not the extension of the low half.
   always_comb begin
      if (mul_signed_r)
         mul_ovf = (mul_product[2*WIDTH-1:WIDTH] != {WIDTH{mul_product[WIDTH-1]}});
      else
         mul_ovf = (mul_product[2*WIDTH-1:WIDTH] != '0);
   end

   // Result registers: loaded on single-cycle accept or multiply completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z            <= '0;
         z_hi         <= '0;
         zero         <= 1'b0;
         equal        <= 1'b0;
         overflow     <= 1'b0;
         illegal      <= 1'b0;
         mul_signed_r <= 1'b0;
      end else if (accept && !is_mul_op) begin
         z        <= alu_z;
         z_hi     <= '0;
         zero     <= alu_zero;
         equal    <= alu_equal;
         overflow <= alu_ovf;
         illegal  <= alu_ill;
      end else if (accept) begin
         equal        <= (x == y);
         mul_signed_r <= (op_e == OP_MUL);
      end else if ((state == MUL) && mul_done) begin
         z        <= mul_product[WIDTH-1:0];
         z_hi     <= mul_product[2*WIDTH-1:WIDTH];
         zero     <= (mul_product[WIDTH-1:0] == '0);
         overflow <= mul_ovf;
         illegal  <= 1'b0;
      end
   end

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (mul_start),
      .signed_mode (op_e == OP_MUL),
      .a           (x),
      .b           (y),
      .done        (mul_done),
      .product     (mul_product)
   );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops compared
// against an arithmetic reference model.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      logic [W-1:0] z;
      logic [W-1:0] hi;
      logic         zero;
      logic         eq;
      logic         ovf;
      logic         ill;
      int           lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [3:0]   op;
   logic [W-1:0] x, y, z, z_hi;
   logic         zero, equal, overflow, illegal;
   alu_state_e   dbg_state;

   int           n_checks = 0;
   int           n_fails  = 0;
   logic [W-1:0] exp_q[$];

   // Clock.
   always #5 clk = ~clk;

   alu_mc #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .z_hi      (z_hi),
      .zero      (zero),
      .equal     (equal),
      .overflow  (overflow),
      .illegal   (illegal),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference model: plain signed/unsigned 64-bit arithmetic.
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t         e;
      longint       sa, sb, r;
      logic [63:0]  p;
      int           s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = int'(b[4:0]);
      e.z = '0; e.hi = '0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1;
      case (o)
         4'd0:  e.z = a & b;
         4'd1:  begin r = sa + sb; p = r; e.z = p[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
         4'd2:  begin r = sa - sb; p = r; e.z = p[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
         4'd3:  e.z = (sa < sb) ? 32'd1 : 32'd0;
         4'd4:  e.z = a >> s;
         4'd5:  begin r = sa >>> s; p = r; e.z = p[31:0]; end
         4'd6:  e.z = a << s;
         4'd8:  e.z = a | b;
         4'd9:  e.z = a ^ b;
         4'd10: e.z = ~(a | b);
         4'd11: e.z = (a < b) ? 32'd1 : 32'd0;
         4'd12: begin
            p = {32'd0, a} * {32'd0, b};
            e.z = p[31:0]; e.hi = p[63:32]; e.ovf = (p[63:32] != 0); e.lat = W;
         end
         4'd13: begin
            r = sa * sb; p = r;
            e.z = p[31:0]; e.hi = p[63:32]; e.ovf = (r > SMAX) || (r < SMIN); e.lat = W;
         end
         default: e.ill = 1'b1;
      endcase
      e.zero = !e.ill && (e.z == 0);
      e.eq   = !e.ill && (a == b);
      return e;
   endfunction

   // Driver: issue one op (called at a negedge), check latency and outputs,
   // hold out_ready low for 'stall' extra cycles. Optional directed z/z_hi.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int stall, input bit use_want,
                         input logic [W-1:0] want_z, input logic [W-1:0] want_hi);
      exp_t e;
      int   k, lat;
      e = model(o, a, b);
      out_ready = (stall == 0);
      op = o; x = a; y = b; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 200) begin @(negedge clk); k++; end
      check({tag, " accept"}, 64'(k < 200), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      op = 4'($urandom); x = $urandom; y = $urandom;
      lat = 1;
      while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
      check({tag, " latency"}, 64'(lat), 64'(e.lat));
      for (int s = 0; s <= stall; s++) begin
         check({tag, " out_valid"}, 64'(out_valid), 64'd1);
         check({tag, " z"}, 64'(z), 64'(e.z));
         check({tag, " z_hi"}, 64'(z_hi), 64'(e.hi));
         check({tag, " zero"}, 64'(zero), 64'(e.zero));
         check({tag, " equal"}, 64'(equal), 64'(e.eq));
         check({tag, " overflow"}, 64'(overflow), 64'(e.ovf));
         check({tag, " illegal"}, 64'(illegal), 64'(e.ill));
         if (use_want) begin
            check({tag, " z directed"}, 64'(z), 64'(want_z));
            check({tag, " z_hi directed"}, 64'(z_hi), 64'(want_hi));
         end
         if (s == stall) out_ready = 1'b1;
         @(negedge clk);
      end
      check({tag, " drained"}, 64'(out_valid), 64'd0);
      check({tag, " ready after"}, 64'(in_ready), 64'd1);
   endtask

   // Watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   seen;
      logic [3:0] ro;
      in_valid = 1'b0; op = '0; x = '0; y = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset z", 64'(z), 64'd0);
      check("reset z_hi", 64'(z_hi), 64'd0);
      check("reset flags", 64'({zero, equal, overflow, illegal}), 64'd0);
      check("reset state", 64'(dbg_state), 64'(IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases.
      run_op("add_ovf", 4'd1, 32'h7FFF_FFFF, 32'd1, 0, 1'b1, 32'h8000_0000, 32'd0);
      run_op("sub_eq", 4'd2, 32'd5, 32'd5, 0, 1'b1, 32'd0, 32'd0);
      run_op("slt", 4'd3, 32'h8000_0000, 32'd1, 0, 1'b1, 32'd1, 32'd0);
      run_op("sltu", 4'd11, 32'h8000_0000, 32'd1, 0, 1'b1, 32'd0, 32'd0);
      run_op("sra", 4'd5, 32'h8000_0000, 32'h21, 0, 1'b1, 32'hC000_0000, 32'd0);
      run_op("sll", 4'd6, 32'd1, 32'd31, 0, 1'b1, 32'h8000_0000, 32'd0);
      run_op("mul_hold", 4'd13, 32'hFFFF_FFFD, 32'd7, 3, 1'b1, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
      run_op("mulu", 4'd12, 32'h1_0000, 32'h1_0000, 0, 1'b1, 32'd0, 32'd1);
      run_op("mul_min", 4'd13, 32'h8000_0000, 32'h8000_0000, 1, 1'b1, 32'd0, 32'h4000_0000);

      // Stream of four ADDs, one result per cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [W-1:0] a, b;
         if (i > 0) begin
            check("stream out_valid", 64'(out_valid), 64'd1);
            check("stream z", 64'(z), 64'(exp_q.pop_front()));
         end
         check("stream in_ready", 64'(in_ready), 64'd1);
         if (i < 4) begin
            a = $urandom; b = $urandom;
            e = model(4'd1, a, b);
            exp_q.push_back(e.z);
            op = 4'd1; x = a; y = b; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("stream drained", 64'(out_valid), 64'd0);

      // Reset in the middle of a MULU.
      op = 4'd12; x = 32'h1234; y = 32'h5678; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort in_ready", 64'(in_ready), 64'd1);
      check("abort z", 64'(z), 64'd0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      check("abort no result", 64'(seen), 64'd0);
      run_op("and_after_rst", 4'd0, 32'hF0, 32'h3C, 0, 1'b1, 32'h30, 32'd0);
      run_op("reserved7", 4'd7, 32'hFFFF, 32'hFFFF, 1, 1'b1, 32'd0, 32'd0);

      // Randomized ops over the whole op space.
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] a, b;
         ro = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 8)) : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         run_op("random", ro, a, b, int'($urandom_range(0, 2)), 1'b0, '0, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU with a valid/ready handshake on both sides. It executes the base single-cycle operations (AND/ADD/SUB/SLT/shifts) with one registered cycle of latency. It adds OR/XOR/NOR/SLTU and an iterative WIDTH-cycle multiplier that returns a double-width product. It sits between the decode/issue stage and writeback of the datapath, and replaces the purely combinational ALU wherever a registered, back-pressurable execute unit is needed.

## Interface
- `WIDTH`, 32, operand/result width (≥ 4, power of two); localparam `SHAMT_W = $clog2(WIDTH)`
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands/op presented
- `in_ready`  out  1  block can accept; transfer when `in_valid && in_ready`
- `op`  in  4  operation (encoding below)
- `x`, `y`  in  WIDTH  operands
- `out_valid`  out  1  result registered and held
- `out_ready`  in  1  consumer takes result when `out_valid && out_ready`
- `z`  out  WIDTH  result (low half for MUL/MULU)
- `z_hi`  out  WIDTH  product high half; 0 for non-multiply ops
- `zero`, `equal`, `overflow`, `illegal`  out  1 each  flags, registered with `z`

## Operation
- Op codes: 0000 AND, 0001 ADD, 0010 SUB, 0011 SLT (signed), 0100 SRL, 0101 SRA, 0110 SLL, 1000 OR, 1001 XOR, 1010 NOR, 1011 SLTU, 1100 MULU, 1101 MUL (signed); 0111, 1110, 1111 reserved.
- Shifts shift `x` by `y[SHAMT_W-1:0]`; the upper bits of `y` are ignored.
- SLT/SLTU produce 1 or 0 in bit 0. SLT is correct even when `x-y` overflows.
- `zero` = (`z`==0). `equal` = (`x`==`y`), using the captured operands.
- `overflow`: signed overflow for ADD/SUB. For MUL: the product is not representable in WIDTH signed bits, i.e. `z_hi` is not the sign-extension of `z[WIDTH-1]`. For MULU: `z_hi`!=0. It is 0 for all other ops.
- Reserved op: `illegal`=1, `z`=`z_hi`=0, all other flags 0. The op still completes with one-cycle latency.
- Multiplier: radix-2 shift-add on operand magnitudes over WIDTH iterations. For MUL the sign is applied in the final cycle (two's-complement negate of the 2·WIDTH result when the operand signs differ).
- FSM states:
  - IDLE: `in_ready`=1. Accepting a single-cycle op goes to DONE; accepting MUL/MULU goes to MUL with the iteration counter at 0.
  - MUL: `in_ready`=0. The counter increments each cycle. At count WIDTH-1, go to DONE with the result registered.
  - DONE: `out_valid`=1 and outputs stable. On `out_ready`: if `in_valid`, accept the new op in the same cycle (next state as from IDLE); else go to IDLE.
- `in_ready` = IDLE | (DONE & `out_ready`), derived combinationally from state.

## Timing
- Reset (async assert, synchronous release by the flops): state IDLE, counter 0, `out_valid`=0, `z`=`z_hi`=0, all flags 0.
- Single-cycle op: accepted in cycle N, `out_valid` in cycle N+1.
- MUL/MULU: accepted in cycle N, `out_valid` in cycle N+WIDTH.
- Throughput is one single-cycle op per clock while `out_ready`=1.
- With `out_ready`=0, `z`, `z_hi` and the flags hold unchanged until the handshake.
- `in_valid` with `in_ready`=0 is ignored. The source holds its request; the block does not sample it.
- `rst_n` low during MUL or DONE aborts the operation; no `out_valid` is produced for it.
- `x`/`y`/`op` are sampled only at acceptance. Later changes do not affect an in-flight multiply.

## Structure
- `alu_pkg`: `alu_op_e` enum (4-bit, codes above), `alu_state_e` {IDLE, MUL, DONE}, and a helper function for signed-overflow detection.
- Sub-module `alu_mul_iter`: iterative multiplier with `start`, `done`, `signed_mode`, and a 2·WIDTH product output.
- The counter width is `SHAMT_W`.

## Test plan
- ADD x=0x7FFFFFFF, y=1 -> z=0x80000000, overflow=1, zero=0; `out_valid` exactly 1 cycle after accept.
- SUB x=y=5 -> z=0, zero=1, equal=1, overflow=0. SLT x=0x80000000, y=1 -> z=1. SLTU with the same operands -> z=0.
- SRA x=0x80000000, y=0x21 -> z=0xC0000000. SLL x=1, y=31 -> z=0x80000000.
- MUL x=-3, y=7 -> z=0xFFFFFFEB, z_hi=0xFFFFFFFF, overflow=0, `out_valid` at accept+32. Hold `out_ready`=0 for 3 cycles -> outputs stable. MULU x=y=0x10000 -> z=0, z_hi=1, overflow=1.
- Stream of 4 ADDs with `out_ready`=1 -> 4 results on 4 consecutive cycles; `in_ready` stays 1.
- `rst_n` pulsed low 10 cycles into a MULU -> `out_valid` stays 0, `in_ready`=1 after release; the next AND (0xF0 & 0x3C) -> z=0x30. Op 0111 -> illegal=1, z=0.
